// File: rtl/pipeline_addsub_pkg.sv
// pipeline_addsub_pkg: shared defaults and elaboration helpers for the slice-pipelined adder/subtractor
package pipeline_addsub_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 4;
    function automatic int num_stages(input int width, input int slice);
        return width / slice;
    endfunction
    function automatic bit geometry_ok(input int width, input int slice);
        return slice > 0 && width >= slice && width % slice == 0;
    endfunction
endpackage

// File: rtl/pipeline_addsub_param_if.sv
// pipeline_addsub_param_if: operand/result handshake bus between producer, adder pipeline and consumer
interface pipeline_addsub_param_if
    import pipeline_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/addsub_slice.sv
// addsub_slice: combinational carry-select slice; both carry-in cases resolved, then muxed on ci
module addsub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cm
);
    logic [W:0] r0;
    logic [W:0] r1;
    assign r0 = {1'b0, a} + {1'b0, b};
    assign r1 = {1'b0, a} + {1'b0, b} + (W+1)'(1);
    assign {co, s} = ci ? r1 : r0;
    // carry into the MSB recovered from the MSB sum bit
    assign cm = s[W-1] ^ a[W-1] ^ b[W-1];
endmodule

// File: rtl/pipeline_addsub_param.sv
// pipeline_addsub_param: slice-pipelined add/sub with skew/deskew, valid/ready backpressure and flush
module pipeline_addsub_param
    import pipeline_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input logic clk,
    input logic reset,
    input logic flush,
    pipeline_addsub_param_if.slave bus
);
    localparam int NS = num_stages(WIDTH, SLICE);

    if (!geometry_ok(WIDTH, SLICE)) begin : g_bad
        $error("pipeline_addsub_param: WIDTH must be a positive multiple of SLICE");
    end

    logic             adv;
    logic             c_eff;
    logic             cm_top;
    logic             ovf_r;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum_w;
    logic [NS-1:0]    v;
    logic [NS-1:0]    cy;
    logic [NS-1:0]    co_w;

    // one global enable: the whole pipeline freezes while the consumer stalls a valid result
    assign adv           = !v[NS-1] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v[NS-1];
    assign bus.sum       = sum_w;
    assign bus.cout      = cy[NS-1];
    assign bus.ovf       = ovf_r;
    assign b_eff         = bus.sub ? ~bus.b : bus.b;
    assign c_eff         = bus.sub ? ~bus.cin : bus.cin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v     <= '0;
            cy    <= '0;
            ovf_r <= 1'b0;
        end else begin
            if (adv) begin
                cy    <= co_w;
                ovf_r <= cm_top ^ co_w[NS-1];
            end
            if (flush) v <= '0;
            else if (adv) v <= (v << 1) | NS'(bus.in_valid);
        end
    end

    for (genvar k = 0; k < NS; k++) begin : g_s
        logic [SLICE-1:0] a_s;
        logic [SLICE-1:0] b_s;
        logic [SLICE-1:0] oa;
        logic [SLICE-1:0] ob;
        logic [SLICE-1:0] s;
        logic             ci;
        logic             cm;
        logic [SLICE-1:0] rs [NS-k];
        assign a_s = bus.a[k*SLICE +: SLICE];
        assign b_s = b_eff[k*SLICE +: SLICE];
        if (k == 0) begin : g_d
            assign oa = a_s;
            assign ob = b_s;
            assign ci = c_eff;
        end else begin : g_d
            // input skew: slice k operands wait k stages for their carry
            logic [SLICE-1:0] sa [k];
            logic [SLICE-1:0] sb [k];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int j = 0; j < k; j++) begin
                        sa[j] <= '0;
                        sb[j] <= '0;
                    end
                end else if (adv) begin
                    sa[0] <= a_s;
                    sb[0] <= b_s;
                    for (int j = 1; j < k; j++) begin
                        sa[j] <= sa[j-1];
                        sb[j] <= sb[j-1];
                    end
                end
            end
            assign oa = sa[k-1];
            assign ob = sb[k-1];
            assign ci = cy[k-1];
        end
        addsub_slice #(.W(SLICE)) u_slice (
            .a  (oa),
            .b  (ob),
            .ci (ci),
            .s  (s),
            .co (co_w[k]),
            .cm (cm)
        );
        // output deskew: slice k result waits NS-1-k more stages so all slices leave together
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int j = 0; j < NS - k; j++) rs[j] <= '0;
            end else if (adv) begin
                rs[0] <= s;
                for (int j = 1; j < NS - k; j++) rs[j] <= rs[j-1];
            end
        end
        assign sum_w[k*SLICE +: SLICE] = rs[NS-k-1];
        if (k == NS - 1) begin : g_o
            assign cm_top = cm;
        end else begin : g_o
            logic unused_cm;
            assign unused_cm = cm;
        end
    end
endmodule

// File: tb/tb_pipeline_addsub_param.sv
// tb_pipeline_addsub_param: directed + random stimulus checked against an arithmetic reference queue
module tb_pipeline_addsub_param;
    localparam int NS = 4;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cnt;
    } exp_t;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;
    exp_t q[$];

    pipeline_addsub_param_if #(.WIDTH(16)) i16 ();
    pipeline_addsub_param_if #(.WIDTH(32)) i32 ();
    pipeline_addsub_param_if #(.WIDTH(8))  i8  ();

    pipeline_addsub_param #(.WIDTH(16), .SLICE(4)) d16 (.clk(clk), .reset(reset), .flush(flush), .bus(i16));
    pipeline_addsub_param #(.WIDTH(32), .SLICE(8)) d32 (.clk(clk), .reset(reset), .flush(flush), .bus(i32));
    pipeline_addsub_param #(.WIDTH(8),  .SLICE(8)) d8  (.clk(clk), .reset(reset), .flush(flush), .bus(i8));

    always #5 clk = ~clk;

    // reference: plain integer arithmetic on unsigned and signed views of the operands
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        exp_t e;
        int ua, ub, sa, sb, c, u, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = int'(cin);
        u  = sub ? ua - ub - c : ua + ub + c;
        s  = sub ? sa - sb - c : sa + sb + c;
        e.sum  = 16'(u);
        e.cout = sub ? (u >= 0) : (u > 65535);
        e.ovf  = (s > 32767) || (s < -32768);
        e.cnt  = 1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // one clock: check visible outputs against the model, update the model, cross the edge
    task automatic tick(output bit acc);
        bit ev, adv;
        #1;
        ev  = q.size() > 0 && q[0].cnt == NS;
        adv = !ev || i16.out_ready;
        chk("out_valid", i16.out_valid, ev);
        chk("in_ready", i16.in_ready, adv);
        if (ev) begin
            chk("sum", i16.sum, q[0].sum);
            chk("cout", i16.cout, q[0].cout);
            chk("ovf", i16.ovf, q[0].ovf);
        end
        acc = i16.in_valid && adv && !flush && !reset;
        if (reset || flush) q.delete();
        else begin
            if (ev && i16.out_ready) void'(q.pop_front());
            if (adv) foreach (q[i]) q[i].cnt++;
            if (acc) q.push_back(model(i16.a, i16.b, i16.cin, i16.sub));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        bit acc;
        int t;
        i16.in_valid = 1'b1;
        i16.a = a;
        i16.b = b;
        i16.cin = cin;
        i16.sub = sub;
        t = 0;
        do begin
            tick(acc);
            t++;
        end while (!acc && t < 20);
        chk("accept", acc, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        i16.in_valid = 1'b0;
        repeat (n) tick(acc);
    endtask

    task automatic zeros(input string tag);
        chk({tag, "_valid"}, i16.out_valid, 0);
        chk({tag, "_sum"}, i16.sum, 0);
        chk({tag, "_cout"}, i16.cout, 0);
        chk({tag, "_ovf"}, i16.ovf, 0);
        chk({tag, "_ready"}, i16.in_ready, 1);
    endtask

    initial begin
        bit acc;
        int cyc, k, l8, l32, n8, n32;
        logic [31:0] s32;
        logic [7:0] s8;
        logic c8, c32;
        checks = 0;
        errors = 0;
        clk = 1'b0;
        reset = 1'b1;
        flush = 1'b0;
        i16.in_valid = 0; i16.a = 0; i16.b = 0; i16.cin = 0; i16.sub = 0; i16.out_ready = 1;
        i32.in_valid = 0; i32.a = 0; i32.b = 0; i32.cin = 0; i32.sub = 0; i32.out_ready = 1;
        i8.in_valid  = 0; i8.a  = 0; i8.b  = 0; i8.cin  = 0; i8.sub  = 0; i8.out_ready  = 1;
        #2;
        zeros("reset");
        chk("reset_v32", i32.out_valid, 0);
        chk("reset_v8", i8.out_valid, 0);
        idle(2);
        reset = 1'b0;
        idle(1);

        op(16'hFFFF, 16'h0001, 0, 0);
        idle(6);

        op(16'h0005, 16'h0007, 0, 1);
        op(16'h7FFF, 16'h0001, 0, 0);
        op(16'h8000, 16'h0001, 0, 1);
        op(16'h0000, 16'h0000, 1, 1);
        idle(6);

        for (int i = 1; i <= 8; i++) op(16'(i), 16'(i), 0, 0);
        idle(6);

        cyc = 0;
        k = 1;
        while (k <= 8 && cyc < 40) begin
            i16.in_valid = 1'b1;
            i16.a = 16'(k);
            i16.b = 16'(k);
            i16.cin = 1'b0;
            i16.sub = 1'b0;
            i16.out_ready = !(cyc >= 5 && cyc <= 7);
            tick(acc);
            if (acc) k++;
            cyc++;
        end
        chk("stall_stream_done", k, 9);
        i16.out_ready = 1'b1;
        idle(6);

        acc = 1'b1;
        for (int n = 0; n < 120; n++) begin
            if (!i16.in_valid || acc) begin
                i16.in_valid = $urandom_range(3) != 0;
                i16.a = 16'($urandom);
                i16.b = 16'($urandom);
                i16.cin = 1'($urandom);
                i16.sub = 1'($urandom);
            end
            i16.out_ready = $urandom_range(9) < 7;
            tick(acc);
        end
        i16.out_ready = 1'b1;
        idle(8);

        op(16'hC000, 16'h8000, 0, 0);
        op(16'h1234, 16'h1111, 0, 0);
        op(16'hFFFF, 16'hFFFF, 1, 0);
        idle(1);
        chk("pre_reset_valid", i16.out_valid, 1);
        reset = 1'b1;
        #1;
        zeros("midreset");
        q.delete();
        idle(2);
        reset = 1'b0;
        idle(8);

        op(16'h0101, 16'h0202, 0, 0);
        op(16'h0303, 16'h0404, 0, 0);
        op(16'h0505, 16'h0606, 0, 0);
        flush = 1'b1;
        i16.a = 16'h1111;
        i16.b = 16'h1111;
        tick(acc);
        flush = 1'b0;
        op(16'h0003, 16'h0004, 0, 0);
        idle(7);

        i32.a = 32'hFFFF_FFFF; i32.b = 32'h1; i32.in_valid = 1'b1;
        i8.a  = 8'hFF;         i8.b  = 8'h1;  i8.in_valid  = 1'b1;
        tick(acc);
        i32.in_valid = 1'b0;
        i8.in_valid = 1'b0;
        l8 = 0; l32 = 0; n8 = 0; n32 = 0; s8 = 'x; s32 = 'x; c8 = 'x; c32 = 'x;
        for (int n = 1; n <= 10; n++) begin
            if (i8.out_valid) begin
                n8++;
                if (l8 == 0) begin l8 = n; s8 = i8.sum; c8 = i8.cout; end
            end
            if (i32.out_valid) begin
                n32++;
                if (l32 == 0) begin l32 = n; s32 = i32.sum; c32 = i32.cout; end
            end
            tick(acc);
        end
        chk("lat_w32", l32, 4);
        chk("sum_w32", s32, 0);
        chk("cout_w32", c32, 1);
        chk("once_w32", n32, 1);
        chk("lat_w8", l8, 1);
        chk("sum_w8", s8, 0);
        chk("cout_w8", c8, 1);
        chk("once_w8", n8, 1);

        chk("drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_addsub_param.md
# pipeline_addsub_param

Parametrised, slice-pipelined adder/subtractor. It is the next generation of the 16-bit four-stage pipelined adder: WIDTH and SLICE are generic, it adds a subtract mode and a signed-overflow flag, and it has a valid/ready handshake with full-pipeline backpressure and flush. It sits between operand-producing datapath stages and downstream consumers that may stall.

## Interface
- WIDTH, 32: operand and result width. Must be a multiple of SLICE and ≥ SLICE.
- SLICE, 4: bits resolved per pipeline stage. NS = WIDTH/SLICE stages.

- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous; clears all in-flight valid bits.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; acts as borrow-in when sub=1.
- sub  in  1  0: a+b+cin; 1: a−b−cin.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB. In subtract mode, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Subtract mode: b_eff = ~b and c_eff = ~cin. Add mode: b_eff = b and c_eff = cin. The sum is always a + b_eff + c_eff, modulo 2^WIDTH.
- Stage k (0..NS−1) adds slice k of a and b_eff with the carry registered by stage k−1; stage 0 uses c_eff.
- Input skew registers delay slice k operands by k stages.
- Output deskew registers delay slice k results by NS−1−k stages, so all slices of one operation leave together.
- Each stage carries one valid bit. out_valid is the valid bit of the last stage.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
- When adv=0, every pipeline register holds its value (valid, data, carries, skew and deskew). Bubbles are not compressed.
- Accept: in_valid && in_ready at a rising edge. If in_valid is high and in_ready is low, the operands are not captured; the producer must hold them.
- flush=1 at an edge clears all valid bits regardless of adv; data registers may keep their values. Same edge with in_valid=1: the operands are dropped and in_ready is unaffected.
- Reset state: all valid bits 0 and all data/carry registers 0, so out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 while and after reset.
- Reset asserted mid-operation discards every in-flight result. After deassertion, the first accept follows normal latency.

## Timing
- Latency: NS cycles. An operand accepted at edge E produces a result on sum/cout/ovf with out_valid=1 after edge E+NS−1, i.e. visible in cycle E+NS. Example: WIDTH=16, SLICE=4 gives latency 4.
- Throughput: one operation per cycle while out_ready=1.
- Each stall cycle (out_valid=1, out_ready=0) adds exactly one cycle to every in-flight operation. Order is preserved.
- Outputs are registered only; no combinational path from a/b to sum.
- in_ready depends combinationally on out_ready and out_valid only.
- Critical path per stage: one SLICE-bit carry-select slice plus carry-in mux.

## Structure
- Shared package pipeline_addsub_pkg:
  - default WIDTH/SLICE constants
  - a function computing NS
  - an elaboration check function for WIDTH % SLICE == 0
- Sub-module addsub_slice: combinational SLICE-bit carry-select slice (dual ripple with cin 0/1, mux on carry-in). It outputs sum, carry out, and the carry into its MSB for ovf on the top slice.
- Top level uses generate loops for the skew/deskew shift registers and per-stage valid bits.

## Test plan
All scenarios use WIDTH=16, SLICE=4 unless stated.
1. a=FFFF, b=0001, cin=0, sub=0, out_ready=1 -> after 4 cycles: sum=0000, cout=1, ovf=0, out_valid for exactly 1 cycle.
2. a=0005, b=0007, cin=0, sub=1 -> sum=FFFE, cout=0, ovf=0. Also a=7FFF, b=0001, sub=0 -> sum=8000, ovf=1. Also a=8000, b=0001, sub=1 -> sum=7FFF, ovf=1.
3. Stream 8 back-to-back operands i+i (i=1..8) with out_ready=1 -> outputs 2,4,…,16 on 8 consecutive cycles starting at cycle 4.
4. Same stream with out_ready low for 3 cycles while out_valid=1 -> in_ready low for those 3 cycles, no result lost or duplicated, order intact.
5. Assert reset 2 cycles after accepting 3 operands -> out_valid, sum, cout, ovf all 0 immediately. No stale result appears after release.
6. flush for 1 cycle with 3 operations in flight -> none emerge. An operand accepted the cycle after the flush emerges 4 cycles later. Repeat scenario 1 with WIDTH=32, SLICE=8 -> latency 4; with WIDTH=8, SLICE=8 -> latency 1.
